// File: rtl/spi_regbank.sv
// spi_regbank: SPI mode-0 register bank with readback on miso, per-write strobe and strict frame checks.
// Define SPI_REGBANK_ERRCNT_EN to add an 8-bit saturating error counter at address NUM_REGS.
module spi_regbank #(
    parameter int NUM_REGS    = 8,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       mosi,
    input  logic                       cs_n,
    output logic                       miso,
    output logic                       miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, DATA, ABORT} state_t;

    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, rdy;
    logic sclk_d, cs_d, sclk_s, mosi_s, cs_s;
    logic cs_rise, cs_fall, sh_rise, sh_fall, full, commit, rd, miso_r;
    logic [CNT_W-1:0] bit_cnt;
    logic [FRAME_LEN-1:0] rx_shift, rx_next;
    logic [DATA_W-1:0] tx_shift, rd_val, f_data;
    logic [ADDR_W-1:0] f_addr;
    logic f_rw;

    // Input synchronisers plus edge-detect flops; rdy marks when the chains hold real pin samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            rdy       <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            rdy       <= {rdy[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign cs_rise = cs_s & ~cs_d;
    assign cs_fall = ~cs_s & cs_d;
    assign sh_rise = sclk_s & ~sclk_d & ~cs_rise & ~cs_fall;
    assign sh_fall = ~sclk_s & sclk_d & ~cs_rise & ~cs_fall;
    assign rx_next = {rx_shift[FRAME_LEN-2:0], mosi_s};
    assign f_rw    = rx_shift[FRAME_LEN-1];
    assign f_addr  = rx_shift[DATA_W +: ADDR_W];
    assign f_data  = rx_shift[DATA_W-1:0];
    assign full    = (state == DATA) && (bit_cnt == CNT_FULL);
    assign commit  = cs_rise && full && f_rw && (f_addr < ADDR_LIM);
    assign miso_oe = (state == DATA) && rd;
    assign miso    = miso_oe & miso_r;

`ifdef SPI_REGBANK_ERRCNT_EN
    logic [7:0] err_cnt;
    logic err_inc, err_clr;
    assign err_clr = cs_rise && full && f_rw && (f_addr == ADDR_LIM);
    assign err_inc = cs_rise && (state == CMD || state == DATA) && (bit_cnt != CNT_FULL || f_addr > ADDR_LIM);

    // Error counter: saturates at 0xFF, clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt <= '0;
        else if (err_clr) err_cnt <= '0;
        else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

    // Readback mux for the address completing on this sclk edge; unmapped addresses read 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rx_next[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_flat[i*DATA_W +: DATA_W];
`ifdef SPI_REGBANK_ERRCNT_EN
        if (rx_next[ADDR_W-1:0] == ADDR_LIM) rd_val = DATA_W'(err_cnt);
`endif
    end

    // Next-state logic; cs_n edges take priority over sclk edges.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cs_fall) state_nx = CMD;
            CMD:     if (cs_rise) state_nx = IDLE;
                     else if (sh_rise && bit_cnt == CNT_ADDR) state_nx = DATA;
            DATA:    if (cs_rise) state_nx = IDLE;
            default: if (rdy[SYNC_STAGES-1] && cs_s) state_nx = IDLE;
        endcase
    end

    // State register; reset lands in ABORT so a frame in flight at reset release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ABORT;
        else state <= state_nx;
    end

    // Receive shifter, saturating bit counter and transmit shifter for readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            rd       <= 1'b0;
            miso_r   <= 1'b0;
        end else begin
            if (state == IDLE || state == ABORT) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sh_rise) begin
                bit_cnt  <= (bit_cnt == CNT_SAT) ? CNT_SAT : bit_cnt + 1'b1;
                rx_shift <= rx_next;
            end
            if (state == CMD && state_nx == DATA) begin
                tx_shift <= rd_val;
                rd       <= ~rx_next[ADDR_W];
                miso_r   <= 1'b0;
            end else if (state == DATA && sh_fall) begin
                miso_r   <= tx_shift[DATA_W-1];
                tx_shift <= tx_shift << 1;
            end
        end
    end

    // Register file update with a one-cycle strobe on each committed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_flat <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= commit;
            if (commit) begin
                wr_addr <= f_addr;
                for (int i = 0; i < NUM_REGS; i++)
                    if (f_addr == ADDR_W'(i)) regs_flat[i*DATA_W +: DATA_W] <= f_data;
            end
        end
    end
endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: table-driven frames for spi_regbank plus reset-mid-frame and back-to-back sequences.
module tb_spi_regbank;
    logic clk = 1'b0;
    logic rst_n, sclk, mosi, cs_n, miso, miso_oe, wr_strobe;
    logic [63:0] regs_flat;
    logic [6:0] wr_addr;

    spi_regbank dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

`ifdef SPI_REGBANK_ERRCNT_EN
    localparam logic [7:0] ERR_RD = 8'h02;
`else
    localparam logic [7:0] ERR_RD = 8'h00;
`endif

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        logic        is_rd;
        int          dstb;
        logic [6:0]  waddr;
        logic [63:0] regs;
        logic [7:0]  rdata;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int strobes = 0;
    int oe_bad;
    logic exp_oe;
    logic [7:0] rd_cap;
    logic [6:0] slog [0:63];

    // Count strobe cycles and log the address seen with each one.
    always @(negedge clk) begin
        if (wr_strobe && strobes < 64) begin
            slog[strobes] = wr_addr;
            strobes++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clock_bits(input logic [31:0] f, input int n, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            mosi = f[n-1-k];
            tick(4);
            if (k >= 8 && k <= 15) begin
                rd_cap = {rd_cap[6:0], miso};
                if (miso_oe !== exp_oe) oe_bad++;
            end else if (miso_oe !== 1'b0) oe_bad++;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] f, input int n, input logic is_rd);
        rd_cap = '0;
        oe_bad = 0;
        exp_oe = is_rd;
        cs_n = 1'b0;
        tick(4);
        clock_bits(f, n, 0, n - 1);
        tick(4);
        cs_n = 1'b1;
    endtask

    vec_t v [13];
    int s0;

    initial begin
        v[0]  = '{32'h83A5,  16, 1'b0, 1, 7'd3, 64'h0000_0000_A500_0000, 8'h00};
        v[1]  = '{32'h0300,  16, 1'b1, 0, 7'd3, 64'h0000_0000_A500_0000, 8'hA5};
        v[2]  = '{32'h412A,  15, 1'b0, 0, 7'd3, 64'h0000_0000_A500_0000, 8'h00};
        v[3]  = '{32'h104AB, 17, 1'b0, 0, 7'd3, 64'h0000_0000_A500_0000, 8'h00};
        v[4]  = '{32'h0800,  16, 1'b1, 0, 7'd3, 64'h0000_0000_A500_0000, ERR_RD};
        v[5]  = '{32'h8955,  16, 1'b0, 0, 7'd3, 64'h0000_0000_A500_0000, 8'h00};
        v[6]  = '{32'h0900,  16, 1'b1, 0, 7'd3, 64'h0000_0000_A500_0000, 8'h00};
        v[7]  = '{32'h8642,  16, 1'b0, 1, 7'd6, 64'h0042_0000_A500_0000, 8'h00};
        v[8]  = '{32'h0642,  16, 1'b1, 0, 7'd6, 64'h0042_0000_A500_0000, 8'h42};
        v[9]  = '{32'h8800,  16, 1'b0, 0, 7'd6, 64'h0042_0000_A500_0000, 8'h00};
        v[10] = '{32'h0800,  16, 1'b1, 0, 7'd6, 64'h0042_0000_A500_0000, 8'h00};
        v[11] = '{32'h80FF,  16, 1'b0, 1, 7'd0, 64'h0042_0000_A500_00FF, 8'h00};
        v[12] = '{32'h0000,  16, 1'b1, 0, 7'd0, 64'h0042_0000_A500_00FF, 8'hFF};

        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        tick(3);
        chk("reset regs", regs_flat, 64'h0);
        chk("reset strobe", {63'h0, wr_strobe}, 64'h0);
        chk("reset wr_addr", {57'h0, wr_addr}, 64'h0);
        chk("reset miso", {62'h0, miso_oe, miso}, 64'h0);
        rst_n = 1'b1;
        tick(5);

        for (int i = 0; i < 13; i++) begin
            s0 = strobes;
            send(v[i].frame, v[i].nbits, v[i].is_rd);
            tick(5);
            chk($sformatf("v%0d regs", i), regs_flat, v[i].regs);
            chk($sformatf("v%0d strobes", i), 64'(strobes - s0), 64'(v[i].dstb));
            chk($sformatf("v%0d wr_addr", i), {57'h0, wr_addr}, {57'h0, v[i].waddr});
            chk($sformatf("v%0d miso data", i), {56'h0, rd_cap}, {56'h0, v[i].rdata});
            chk($sformatf("v%0d miso_oe during frame", i), 64'(oe_bad), 64'h0);
            chk($sformatf("v%0d miso idle", i), {62'h0, miso_oe, miso}, 64'h0);
            tick(4);
        end

        s0 = strobes;
        rd_cap = '0;
        oe_bad = 0;
        exp_oe = 1'b0;
        cs_n = 1'b0;
        tick(4);
        clock_bits(32'h8011, 16, 0, 15);
        tick(4);
        cs_n = 1'b1;
        tick(2);
        send(32'h87EE, 16, 1'b0);
        tick(5);
        chk("b2b regs", regs_flat, 64'hEE42_0000_A500_0011);
        chk("b2b strobes", 64'(strobes - s0), 64'd2);
        chk("b2b first addr", {57'h0, slog[s0]}, 64'd0);
        chk("b2b second addr", {57'h0, slog[s0+1]}, 64'd7);
        tick(4);

        s0 = strobes;
        rd_cap = '0;
        oe_bad = 0;
        exp_oe = 1'b0;
        cs_n = 1'b0;
        tick(4);
        clock_bits(32'h8177, 16, 0, 9);
        rst_n = 1'b0;
        tick(3);
        chk("mid reset regs", regs_flat, 64'h0);
        rst_n = 1'b1;
        tick(4);
        clock_bits(32'h8177, 16, 10, 15);
        tick(4);
        cs_n = 1'b1;
        tick(5);
        chk("aborted frame regs", regs_flat, 64'h0);
        chk("aborted frame strobes", 64'(strobes - s0), 64'd0);
        chk("aborted frame miso_oe", 64'(oe_bad), 64'h0);
        tick(4);
        send(32'h8177, 16, 1'b0);
        tick(5);
        chk("after abort regs", regs_flat, 64'h0000_0000_0000_7700);
        chk("after abort strobes", 64'(strobes - s0), 64'd1);
        chk("after abort wr_addr", {57'h0, wr_addr}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
